// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID peripheral: register word offsets,
// CTRL bit positions, decode selector and the CAPS word layout.
package sysid_pkg;

  localparam int unsigned ADDR_ID    = 0;
  localparam int unsigned ADDR_TS    = 1;
  localparam int unsigned ADDR_UP_LO = 2;
  localparam int unsigned ADDR_UP_HI = 3;
  localparam int unsigned ADDR_CTRL  = 4;
  localparam int unsigned ADDR_SCR0  = 5;

  localparam logic [7:0] SYSID_VERSION = 8'h02;

  localparam int unsigned CTRL_CLR = 0;
  localparam int unsigned CTRL_FRZ = 1;

  typedef enum logic [2:0] {
    REG_ID,
    REG_TS,
    REG_UP_LO,
    REG_UP_HI,
    REG_CTRL,
    REG_SCR,
    REG_NONE
  } reg_sel_e;

  function automatic logic [31:0] caps_word(input int unsigned n_scr,
                                            input int unsigned up_w,
                                            input logic        frz);
    return {SYSID_VERSION, 8'(n_scr), 8'(up_w), 6'b0, frz, 1'b0};
  endfunction

endpackage

// File: rtl/system_0_sysid_ext_if.sv
// Avalon-MM slave bus bundle for the system-ID peripheral (no waitrequest).
interface system_0_sysid_ext_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_uptime_counter.sv
// Free-running uptime counter with a high-word shadow captured on low-word reads,
// so a LO-then-HI read pair never tears.
module sysid_uptime_counter #(
  parameter int unsigned UPTIME_W = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                freeze,
  input  logic                snap,
  output logic [UPTIME_W-1:0] count,
  output logic [31:0]         hi_shadow
);

  logic [UPTIME_W-33:0] shadow_q;

  // Clear has priority over increment and also applies while frozen.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      shadow_q <= '0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (!freeze) begin
        count <= count + UPTIME_W'(1);
      end
      if (snap) begin
        shadow_q <= count[UPTIME_W-1:32];
      end
    end
  end

  assign hi_shadow = 32'(shadow_q);

endmodule

// File: rtl/system_0_sysid_ext.sv
// System-ID peripheral top: address decode, scratch words, CTRL/freeze,
// read mux and the registered one-cycle-latency read response.
module system_0_sysid_ext
  import sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE  = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP = 32'd1720305019,
  parameter int unsigned UPTIME_W  = 64,
  parameter int unsigned N_SCRATCH = 2,
  parameter int unsigned ADDR_W    = 4
) (
  input logic                  clock,
  input logic                  reset_n,
  system_0_sysid_ext_if.slave  avs
);

  if (UPTIME_W < 33 || UPTIME_W > 64) begin : g_chk_uptime_w
    $error("UPTIME_W must be in 33..64");
  end
  if (N_SCRATCH < 1 || N_SCRATCH > 8) begin : g_chk_n_scratch
    $error("N_SCRATCH must be in 1..8");
  end
  if (5 + N_SCRATCH > (1 << ADDR_W)) begin : g_chk_addr_w
    $error("ADDR_W too small for the register map");
  end

  logic [31:0]         addr_w;
  logic                rd_en;
  logic                ctrl_wr;
  logic                freeze_q;
  logic [UPTIME_W-1:0] up_count;
  logic [31:0]         up_hi;
  logic                unused_up_hi;
  logic [31:0]         scratch [N_SCRATCH];
  reg_sel_e            sel;
  logic [31:0]         rd_mux;

  assign addr_w  = 32'(avs.address);
  // A write in the same cycle as a read wins; the read is dropped.
  assign rd_en   = avs.read & ~avs.write;
  assign ctrl_wr = avs.write & (addr_w == ADDR_CTRL);

  always_comb begin
    sel = REG_NONE;
    if (addr_w == ADDR_ID)         sel = REG_ID;
    else if (addr_w == ADDR_TS)    sel = REG_TS;
    else if (addr_w == ADDR_UP_LO) sel = REG_UP_LO;
    else if (addr_w == ADDR_UP_HI) sel = REG_UP_HI;
    else if (addr_w == ADDR_CTRL)  sel = REG_CTRL;
    else if (addr_w >= ADDR_SCR0 && addr_w < ADDR_SCR0 + N_SCRATCH) sel = REG_SCR;
  end

  sysid_uptime_counter #(
    .UPTIME_W(UPTIME_W)
  ) u_uptime (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (ctrl_wr & avs.writedata[CTRL_CLR]),
    .freeze   (freeze_q),
    .snap     (rd_en & (sel == REG_UP_LO)),
    .count    (up_count),
    .hi_shadow(up_hi)
  );

  assign unused_up_hi = ^up_count[UPTIME_W-1:32];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      freeze_q <= 1'b0;
    end else if (ctrl_wr) begin
      freeze_q <= avs.writedata[CTRL_FRZ];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_SCRATCH; i++) scratch[i] <= '0;
    end else if (avs.write) begin
      for (int unsigned i = 0; i < N_SCRATCH; i++) begin
        if (addr_w == ADDR_SCR0 + i) scratch[i] <= avs.writedata;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_ID:    rd_mux = ID_VALUE;
      REG_TS:    rd_mux = TIMESTAMP;
      REG_UP_LO: rd_mux = up_count[31:0];
      REG_UP_HI: rd_mux = up_hi;
      REG_CTRL:  rd_mux = caps_word(N_SCRATCH, UPTIME_W, freeze_q);
      REG_SCR: begin
        for (int unsigned i = 0; i < N_SCRATCH; i++) begin
          if (addr_w == ADDR_SCR0 + i) rd_mux = scratch[i];
        end
      end
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      avs.readdata      <= '0;
      avs.readdatavalid <= 1'b0;
    end else begin
      avs.readdatavalid <= rd_en;
      if (rd_en) avs.readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_system_0_sysid_ext.sv
// Scoreboard bench for system_0_sysid_ext: behavioural register-map model,
// expected read data queued at issue, monitor pops on readdatavalid.
module tb_system_0_sysid_ext;

  localparam logic [31:0] ID_VALUE  = 32'h0000_0000;
  localparam logic [31:0] TIMESTAMP = 32'd1720305019;
  localparam int unsigned UPTIME_W  = 64;
  localparam int unsigned N_SCRATCH = 2;
  localparam int unsigned ADDR_W    = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  system_0_sysid_ext_if #(.ADDR_W(ADDR_W)) bus ();

  system_0_sysid_ext #(
    .ID_VALUE (ID_VALUE),
    .TIMESTAMP(TIMESTAMP),
    .UPTIME_W (UPTIME_W),
    .N_SCRATCH(N_SCRATCH),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .avs    (bus)
  );

  // Reference model state: value held between clock edges.
  logic [63:0] m_up;
  logic [31:0] m_shadow;
  logic        m_frz;
  logic [31:0] m_scr [N_SCRATCH];
  longint      cyc = 0;

  typedef struct {
    logic [31:0] data;
    longint      due;
    int unsigned addr;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rd = '0;

  function automatic logic [31:0] model_read(input int unsigned a);
    if (a == 0) return ID_VALUE;
    if (a == 1) return TIMESTAMP;
    if (a == 2) return m_up[31:0];
    if (a == 3) return m_shadow;
    if (a == 4) return {8'h02, 8'(N_SCRATCH), 8'(UPTIME_W), 6'b0, m_frz, 1'b0};
    if (a >= 5 && a < 5 + N_SCRATCH) return m_scr[a-5];
    return 32'h0;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_up = '0; m_shadow = '0; m_frz = 1'b0;
      for (int i = 0; i < N_SCRATCH; i++) m_scr[i] = '0;
    end else begin
      int unsigned a;
      logic [63:0] old;
      cyc++;
      a   = int'(bus.address);
      old = m_up;
      if (bus.write && a == 4 && bus.writedata[0]) m_up = '0;
      else if (!m_frz) m_up = old + 64'd1;
      if (bus.write) begin
        if (a == 4) m_frz = bus.writedata[1];
        if (a >= 5 && a < 5 + N_SCRATCH) m_scr[a-5] = bus.writedata;
      end else if (bus.read && a == 2) begin
        m_shadow = old[63:32];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      last_rd = '0;
    end else begin
      if (bus.readdatavalid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check($sformatf("rd_addr%0d", e.addr), bus.readdata, e.data);
          check("rd_latency", 32'(cyc - e.due), 32'd0);
        end
      end else begin
        check("rd_hold", bus.readdata, last_rd);
        if (q.size() != 0 && q[0].due <= cyc) begin
          exp_t e;
          e = q.pop_front();
          check($sformatf("missing_valid_addr%0d", e.addr), 32'd0, 32'd1);
        end
      end
      last_rd = bus.readdata;
    end
  end

  task automatic bus_op(input logic rd, input logic wr, input int unsigned a, input logic [31:0] d);
    @(posedge clock);
    #1;
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = ADDR_W'(a);
    bus.writedata = d;
    if (rd && !wr) q.push_back('{data: model_read(a), due: cyc + 1, addr: a});
  endtask

  task automatic idle(input int n);
    repeat (n) bus_op(1'b0, 1'b0, 0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_valid", 32'(bus.readdatavalid), 32'h0);
    reset_n = 1'b1;

    // Identification words and default caps.
    bus_op(1, 0, 0, 0);
    bus_op(1, 0, 1, 0);
    bus_op(1, 0, 4, 0);
    idle(2);

    // Preload near the 32-bit boundary while frozen, then LO/HI pair.
    bus_op(0, 1, 4, 32'h2);
    idle(1);
    force dut.u_uptime.count = 64'h0000_0001_FFFF_FFFF;
    m_up = 64'h0000_0001_FFFF_FFFF;
    idle(1);
    release dut.u_uptime.count;
    bus_op(1, 0, 4, 0);
    bus_op(0, 1, 4, 32'h0);
    bus_op(1, 0, 2, 0);
    idle(2);
    bus_op(1, 0, 3, 0);
    bus_op(1, 0, 2, 0);
    idle(2);

    // Scratch words and an unmapped address.
    bus_op(0, 1, 5, 32'hDEAD_BEEF);
    bus_op(1, 0, 5, 0);
    bus_op(0, 1, 6, 32'h1234_5678);
    bus_op(1, 0, 6, 0);
    bus_op(1, 0, 12, 0);
    bus_op(0, 1, 3, 32'hFFFF_FFFF);
    bus_op(1, 0, 3, 0);
    idle(2);

    // Clear while running, then clear while frozen.
    bus_op(0, 1, 4, 32'h1);
    bus_op(1, 0, 2, 0);
    idle(3);
    bus_op(0, 1, 4, 32'h3);
    bus_op(1, 0, 2, 0);
    idle(3);
    bus_op(1, 0, 2, 0);
    bus_op(1, 0, 4, 0);
    bus_op(0, 1, 4, 32'h0);
    idle(2);

    // Read and write together: write wins, no response.
    bus_op(1, 1, 5, 32'hA5A5_A5A5);
    bus_op(1, 0, 5, 0);
    idle(2);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      int unsigned a, kind;
      logic [31:0] d;
      a    = $urandom_range(0, 15);
      kind = $urandom_range(0, 9);
      d    = $urandom;
      if (a == 4) d[1] = ($urandom_range(0, 3) == 0);
      if (kind <= 4)      bus_op(1, 0, a, d);
      else if (kind <= 6) bus_op(0, 1, a, d);
      else if (kind == 7) bus_op(1, 1, a, d);
      else                bus_op(0, 0, a, d);
    end
    idle(3);

    // Reset asserted after the read is accepted but before it is seen.
    bus_op(0, 1, 4, 32'h0);
    bus_op(0, 1, 6, 32'h0BAD_F00D);
    bus_op(1, 0, 6, 0);
    @(posedge clock);
    #2;
    bus.read = 1'b0;
    reset_n  = 1'b0;
    q.delete();
    #1;
    check("midreset_valid", 32'(bus.readdatavalid), 32'h0);
    check("midreset_readdata", bus.readdata, 32'h0);
    check("midreset_scratch1", dut.scratch[1], 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    bus_op(1, 0, 5, 0);
    bus_op(1, 0, 6, 0);
    bus_op(1, 0, 3, 0);
    bus_op(1, 0, 2, 0);
    idle(2);

    for (int w = 0; w < 20 && q.size() != 0; w++) @(posedge clock);
    if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'h0);
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
